// File: rtl/fft_wb_addr_gen_if.sv
// Handshake and write-port bundle between the butterfly output strobe,
// the write-back address sequencer and the data RAM write port.
interface fft_wb_addr_gen_if;
  logic       start;
  logic       valid;
  logic       busy;
  logic [4:0] waddr;
  logic       we;
  logic [2:0] wstage;
  logic       done;

  modport master (
    output start, valid,
    input  busy, waddr, we, wstage, done
  );

  modport slave (
    input  start, valid,
    output busy, waddr, we, wstage, done
  );
endinterface

// File: rtl/fft_wb_addr_gen.sv
// Write-back address sequencer for the 32-point radix-2 FFT: each accepted
// result index is rotated right by the stage number to undo the read-side rotation.
//
// state | meaning
// IDLE  | waiting for start; valid ignored
// RUN   | accepting butterfly results, 32 per stage over 5 stages
module fft_wb_addr_gen (
  input  logic               clk,
  input  logic               clr,
  fft_wb_addr_gen_if.slave   bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t     state, state_nx;
  logic [4:0] cnt, cnt_nx;
  logic [2:0] stage, stage_nx;
  logic [2:0] stage_eff;
  logic [4:0] waddr, waddr_nx;
  logic [2:0] wstage, wstage_nx;
  logic       we, we_nx;
  logic       done, done_nx;

  function automatic logic [4:0] rotr(input logic [4:0] v, input logic [2:0] s);
    logic [4:0] r;
    case (s)
      3'd0:    r = v;
      3'd1:    r = {v[0],   v[4:1]};
      3'd2:    r = {v[1:0], v[4:2]};
      3'd3:    r = {v[2:0], v[4:3]};
      default: r = {v[3:0], v[4]};
    endcase
    return r;
  endfunction

  // Stages 5..7 cannot occur in normal operation; fold them onto the last stage.
  assign stage_eff = (stage > 3'd4) ? 3'd4 : stage;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    stage_nx  = stage;
    waddr_nx  = waddr;
    wstage_nx = wstage;
    we_nx     = 1'b0;
    done_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = RUN;
          cnt_nx   = 5'd0;
          stage_nx = 3'd0;
        end
      end
      RUN: begin
        if (bus.valid) begin
          we_nx     = 1'b1;
          waddr_nx  = rotr(cnt, stage_eff);
          wstage_nx = stage_eff;
          if (cnt != 5'd31) begin
            cnt_nx = cnt + 5'd1;
          end else if (stage_eff != 3'd4) begin
            cnt_nx   = 5'd0;
            stage_nx = stage + 3'd1;
          end else begin
            done_nx  = 1'b1;
            state_nx = IDLE;
            cnt_nx   = 5'd0;
            stage_nx = 3'd0;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      stage  <= 3'd0;
      waddr  <= 5'd0;
      wstage <= 3'd0;
      we     <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      stage  <= stage_nx;
      waddr  <= waddr_nx;
      wstage <= wstage_nx;
      we     <= we_nx;
      done   <= done_nx;
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.waddr  = waddr;
  assign bus.wstage = wstage;
  assign bus.we     = we;
  assign bus.done   = done;

endmodule
